// File: rtl/flexbex_efpga_responder_if.sv
// Core/fabric bundle for the eFPGA custom-instruction responder.
// slave  : responder view (drives ready/result and the fabric launch side)
// master : core + fabric view (drives the request and the fabric result)
interface flexbex_efpga_responder_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  en_i;
   logic [1:0]            operator_i;
   logic [3:0]            delay_i;
   logic [DATA_WIDTH-1:0] operand_a_i;
   logic [DATA_WIDTH-1:0] operand_b_i;
   logic                  ready_o;
   logic [DATA_WIDTH-1:0] result_o;
   logic                  error_o;
   logic                  busy_o;
   logic [DATA_WIDTH-1:0] fabric_op_a_o;
   logic [DATA_WIDTH-1:0] fabric_op_b_o;
   logic [1:0]            fabric_operator_o;
   logic                  fabric_strobe_o;
   logic [DATA_WIDTH-1:0] fabric_result_i;
   logic                  fabric_done_i;

   modport slave (
      input  en_i, operator_i, delay_i, operand_a_i, operand_b_i,
      input  fabric_result_i, fabric_done_i,
      output ready_o, result_o, error_o, busy_o,
      output fabric_op_a_o, fabric_op_b_o, fabric_operator_o, fabric_strobe_o
   );

   modport master (
      output en_i, operator_i, delay_i, operand_a_i, operand_b_i,
      output fabric_result_i, fabric_done_i,
      input  ready_o, result_o, error_o, busy_o,
      input  fabric_op_a_o, fabric_op_b_o, fabric_operator_o, fabric_strobe_o
   );
endinterface

// File: rtl/flexbex_efpga_responder.sv
// eFPGA custom-instruction responder: latches a core request, strobes the
// fabric once, waits a fixed latency or for fabric_done_i (with timeout),
// then returns a registered result with a one-cycle ready pulse.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | waiting for en_i; fabric_* registers hold the last request
// S_LAUNCH | fabric_strobe_o high for this cycle only; done ignored
// S_WAIT   | fixed mode: count dly_cnt down; handshake: wait done/timeout
// S_RESP   | ready_o pulse, error_o = error flag; en_i ignored
module flexbex_efpga_responder #(
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 64
) (
   input logic                   clk,
   input logic                   rst_n,
   flexbex_efpga_responder_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LAUNCH = 2'd1,
      S_WAIT   = 2'd2,
      S_RESP   = 2'd3
   } state_t;

   localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

   state_t                state_q,    state_d;
   logic [DATA_WIDTH-1:0] op_a_q,     op_a_d;
   logic [DATA_WIDTH-1:0] op_b_q,     op_b_d;
   logic [1:0]            operator_q, operator_d;
   logic [3:0]            delay_q,    delay_d;
   logic [3:0]            dly_cnt_q,  dly_cnt_d;
   logic [7:0]            to_cnt_q,   to_cnt_d;
   logic [DATA_WIDTH-1:0] result_q,   result_d;
   logic                  err_q,      err_d;

   // Next-state and datapath update for the request/launch/wait/respond sequence.
   always_comb begin
      state_d    = state_q;
      op_a_d     = op_a_q;
      op_b_d     = op_b_q;
      operator_d = operator_q;
      delay_d    = delay_q;
      dly_cnt_d  = dly_cnt_q;
      to_cnt_d   = to_cnt_q;
      result_d   = result_q;
      err_d      = err_q;

      unique case (state_q)
         S_IDLE: begin
            if (bus.en_i) begin
               op_a_d     = bus.operand_a_i;
               op_b_d     = bus.operand_b_i;
               operator_d = bus.operator_i;
               delay_d    = bus.delay_i;
               dly_cnt_d  = bus.delay_i;
               to_cnt_d   = 8'd0;
               err_d      = 1'b0;
               state_d    = S_LAUNCH;
            end
         end
         S_LAUNCH: begin
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (delay_q != 4'd0) begin
               if (dly_cnt_q == 4'd1) begin
                  result_d = bus.fabric_result_i;
                  err_d    = 1'b0;
                  state_d  = S_RESP;
               end else begin
                  dly_cnt_d = dly_cnt_q - 4'd1;
               end
            end else if (bus.fabric_done_i) begin
               // done takes priority over a coincident timeout
               result_d = bus.fabric_result_i;
               err_d    = 1'b0;
               state_d  = S_RESP;
            end else if (to_cnt_q == TO_LAST) begin
               result_d = '0;
               err_d    = 1'b1;
               state_d  = S_RESP;
            end else begin
               to_cnt_d = to_cnt_q + 8'd1;
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         op_a_q     <= '0;
         op_b_q     <= '0;
         operator_q <= '0;
         delay_q    <= '0;
         dly_cnt_q  <= '0;
         to_cnt_q   <= '0;
         result_q   <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         op_a_q     <= op_a_d;
         op_b_q     <= op_b_d;
         operator_q <= operator_d;
         delay_q    <= delay_d;
         dly_cnt_q  <= dly_cnt_d;
         to_cnt_q   <= to_cnt_d;
         result_q   <= result_d;
         err_q      <= err_d;
      end
   end

   assign bus.ready_o           = (state_q == S_RESP);
   assign bus.error_o           = (state_q == S_RESP) && err_q;
   assign bus.busy_o            = (state_q != S_IDLE);
   assign bus.fabric_strobe_o   = (state_q == S_LAUNCH);
   assign bus.result_o          = result_q;
   assign bus.fabric_op_a_o     = op_a_q;
   assign bus.fabric_op_b_o     = op_b_q;
   assign bus.fabric_operator_o = operator_q;

endmodule

// File: tb/tb_flexbex_efpga_responder.sv
// Bench for flexbex_efpga_responder: directed scenarios followed by random
// transactions, each checked against a cycle-offset model of the request.
module tb_flexbex_efpga_responder;

   localparam int DW = 32;
   localparam int T  = 8;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   logic [DW-1:0] prev_a, prev_b, prev_res;
   logic [1:0]    prev_op;

   flexbex_efpga_responder_if #(.DATA_WIDTH(DW)) bus ();

   flexbex_efpga_responder #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(T)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Entered at the negedge of the acceptance cycle; returns at the negedge of
   // the ready cycle. k: WAIT cycle index at which done is driven (k > T: never).
   task automatic run_txn(input logic [3:0] d, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [1:0] op, input logic [DW-1:0] fres, input bit rnd_res,
                          input int k, input bit launch_done, input bit hold_en);
      int            lat;
      int            cap_c;
      bit            err_exp;
      logic [DW-1:0] exp_res;
      logic [DW-1:0] fr;

      if (d != 4'd0) begin
         lat = int'(d) + 2; cap_c = int'(d) + 1; err_exp = 1'b0;
      end else if (k <= T) begin
         lat = k + 2; cap_c = k + 1; err_exp = 1'b0;
      end else begin
         lat = T + 2; cap_c = -1; err_exp = 1'b1;
      end
      exp_res = '0;

      chk("idle_busy",  {31'd0, bus.busy_o}, 32'd0);
      chk("idle_ready", {31'd0, bus.ready_o}, 32'd0);
      chk("idle_hold_a", bus.fabric_op_a_o, prev_a);
      chk("idle_hold_op", {30'd0, bus.fabric_operator_o}, {30'd0, prev_op});
      chk("idle_result_hold", bus.result_o, prev_res);

      bus.en_i            = 1'b1;
      bus.delay_i         = d;
      bus.operand_a_i     = a;
      bus.operand_b_i     = b;
      bus.operator_i      = op;
      bus.fabric_done_i   = 1'b0;
      bus.fabric_result_i = $urandom;

      for (int c = 1; c <= lat; c++) begin
         next_cycle();
         chk("strobe", {31'd0, bus.fabric_strobe_o}, {31'd0, (c == 1)});
         chk("ready",  {31'd0, bus.ready_o}, {31'd0, (c == lat)});
         chk("error",  {31'd0, bus.error_o}, {31'd0, (c == lat) && err_exp});
         chk("busy",   {31'd0, bus.busy_o}, 32'd1);
         chk("fab_a",  bus.fabric_op_a_o, a);
         chk("fab_b",  bus.fabric_op_b_o, b);
         chk("fab_op", {30'd0, bus.fabric_operator_o}, {30'd0, op});
         if (c == lat) chk("result", bus.result_o, exp_res);

         // drive inputs for this cycle; operands change to junk after acceptance
         bus.operand_a_i = $urandom;
         bus.operand_b_i = $urandom;
         bus.operator_i  = 2'($urandom);
         bus.delay_i     = 4'($urandom);
         bus.en_i        = hold_en ? 1'b1 : 1'($urandom);
         fr = rnd_res ? DW'($urandom) : fres;
         bus.fabric_result_i = fr;
         if (c == cap_c) exp_res = fr;
         if (d != 4'd0)  bus.fabric_done_i = 1'($urandom);
         else if (c == 1) bus.fabric_done_i = launch_done;
         else             bus.fabric_done_i = (c == k + 1);
         if (c == lat)    bus.fabric_done_i = 1'b0;
      end

      prev_a = a; prev_b = b; prev_op = op; prev_res = exp_res;
   endtask

   initial begin
      checks = 0; failures = 0;
      prev_a = '0; prev_b = '0; prev_op = '0; prev_res = '0;
      rst_n = 1'b0;
      bus.en_i = 1'b1; bus.delay_i = 4'd2; bus.operator_i = 2'd3;
      bus.operand_a_i = 32'hdead; bus.operand_b_i = 32'hbeef;
      bus.fabric_result_i = 32'h5555; bus.fabric_done_i = 1'b1;

      // reset held with a pending request
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         next_cycle();
         chk("rst_ready",  {31'd0, bus.ready_o}, 32'd0);
         chk("rst_strobe", {31'd0, bus.fabric_strobe_o}, 32'd0);
         chk("rst_busy",   {31'd0, bus.busy_o}, 32'd0);
         chk("rst_error",  {31'd0, bus.error_o}, 32'd0);
         chk("rst_result", bus.result_o, 32'd0);
         chk("rst_fab_a",  bus.fabric_op_a_o, 32'd0);
         chk("rst_fab_b",  bus.fabric_op_b_o, 32'd0);
         chk("rst_fab_op", {30'd0, bus.fabric_operator_o}, 32'd0);
      end
      rst_n = 1'b1;

      // fixed latency 3, accepted in the first cycle after reset release
      run_txn(4'd3, 32'h11, 32'h22, 2'd2, 32'hCAFE0000, 1'b0, 0, 1'b0, 1'b0);
      next_cycle();
      // handshake: done 6 cycles after LAUNCH, with a spurious done in LAUNCH
      run_txn(4'd0, 32'h33, 32'h44, 2'd1, 32'h1234, 1'b0, 6, 1'b1, 1'b0);
      next_cycle();
      // timeout, done never seen
      run_txn(4'd0, 32'h55, 32'h66, 2'd0, 32'h9999, 1'b0, T + 5, 1'b0, 1'b0);
      next_cycle();
      // done on the last WAIT cycle wins over timeout
      run_txn(4'd0, 32'h77, 32'h88, 2'd3, 32'hABCD, 1'b0, T, 1'b0, 1'b0);
      next_cycle();
      // back-to-back with en_i held high, D=1
      run_txn(4'd1, 32'hA1, 32'hB1, 2'd1, 32'h0F0F, 1'b0, 0, 1'b0, 1'b1);
      next_cycle();
      run_txn(4'd1, 32'hA2, 32'hB2, 2'd2, 32'hF0F0, 1'b0, 0, 1'b0, 1'b0);
      next_cycle();

      // reset in the middle of a D=15 wait
      bus.en_i = 1'b1; bus.delay_i = 4'd15; bus.operator_i = 2'd1;
      bus.operand_a_i = 32'hC1; bus.operand_b_i = 32'hC2;
      for (int i = 0; i < 5; i++) next_cycle();
      chk("midrst_busy_before", {31'd0, bus.busy_o}, 32'd1);
      rst_n = 1'b0;
      next_cycle();
      chk("midrst_busy",   {31'd0, bus.busy_o}, 32'd0);
      chk("midrst_ready",  {31'd0, bus.ready_o}, 32'd0);
      chk("midrst_result", bus.result_o, 32'd0);
      chk("midrst_fab_a",  bus.fabric_op_a_o, 32'd0);
      rst_n = 1'b1;
      bus.en_i = 1'b0;
      for (int i = 0; i < 20; i++) begin
         next_cycle();
         chk("postrst_ready",  {31'd0, bus.ready_o}, 32'd0);
         chk("postrst_strobe", {31'd0, bus.fabric_strobe_o}, 32'd0);
      end
      prev_a = '0; prev_b = '0; prev_op = '0; prev_res = '0;

      // random transactions with random idle gaps
      for (int n = 0; n < 40; n++) begin
         logic [3:0] d;
         int gap;
         d = 4'($urandom);
         if ($urandom_range(0, 2) == 0) d = 4'd0;
         run_txn(d, $urandom, $urandom, 2'($urandom), $urandom, 1'b1,
                 $urandom_range(1, T + 2), 1'($urandom), 1'($urandom));
         next_cycle();
         gap = $urandom_range(0, 2);
         for (int g = 0; g < gap; g++) begin
            bus.en_i = 1'b0;
            next_cycle();
            chk("gap_busy",  {31'd0, bus.busy_o}, 32'd0);
            chk("gap_ready", {31'd0, bus.ready_o}, 32'd0);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
